// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counter with registered sync/blank decode.
// Flags are decoded from the next-state counts so they land on the same edge as the counts.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counters");
    end
  endgenerate

  // 12-bit thresholds so a sync end of exactly 2048 does not alias to 0
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_BLNK = 12'(H_VISIBLE);
  localparam logic [11:0] H_SS   = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_BLNK = 12'(V_VISIBLE);
  localparam logic [11:0] V_SS   = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        hsync_q, hsync_d, hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d, vblnk_q, vblnk_d;
  logic        fs_q, fs_d;
  logic        h_wrap, v_wrap;

  assign h_wrap = ({1'b0, hcnt_q} == H_LAST);
  assign v_wrap = ({1'b0, vcnt_q} == V_LAST);

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hsync_d = hsync_q;
    hblnk_d = hblnk_q;
    vsync_d = vsync_q;
    vblnk_d = vblnk_q;
    fs_d    = 1'b0;
    if (en) begin
      hcnt_d = h_wrap ? 11'd0 : hcnt_q + 11'd1;
      if (h_wrap) vcnt_d = v_wrap ? 11'd0 : vcnt_q + 11'd1;
      hblnk_d = ({1'b0, hcnt_d} >= H_BLNK);
      hsync_d = (({1'b0, hcnt_d} >= H_SS) && ({1'b0, hcnt_d} < H_SE)) ~^ SYNC_POL;
      vblnk_d = ({1'b0, vcnt_d} >= V_BLNK);
      vsync_d = (({1'b0, vcnt_d} >= V_SS) && ({1'b0, vcnt_d} < V_SE)) ~^ SYNC_POL;
      fs_d    = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= ~SYNC_POL;
      hblnk_q <= 1'b0;
      vsync_q <= ~SYNC_POL;
      vblnk_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      hblnk_q <= hblnk_d;
      vsync_q <= vsync_d;
      vblnk_q <= vblnk_d;
      fs_q    <= fs_d;
    end
  end

  assign hcount_out  = hcnt_q;
  assign vcount_out  = vcnt_q;
  assign hsync_out   = hsync_q;
  assign hblnk_out   = hblnk_q;
  assign vsync_out   = vsync_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 800x600 default, 640x480 active-low, and two tiny rasters for frame-level checks.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 pclk = ~pclk;

  // default 800x600 mode
  logic [10:0] d_h, d_v;
  logic        d_hs, d_hb, d_vs, d_vb, d_fs;
  vga_timing_gen u_d (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount_out(d_h), .hsync_out(d_hs), .hblnk_out(d_hb),
    .vcount_out(d_v), .vsync_out(d_vs), .vblnk_out(d_vb), .frame_start(d_fs));

  // 640x480, active-low syncs
  logic [10:0] g_h, g_v;
  logic        g_hs, g_hb, g_vs, g_vb, g_fs;
  vga_timing_gen #(.H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                   .V_VISIBLE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b0)) u_g (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount_out(g_h), .hsync_out(g_hs), .hblnk_out(g_hb),
    .vcount_out(g_v), .vsync_out(g_vs), .vblnk_out(g_vb), .frame_start(g_fs));

  // tiny 15x8 raster, active-high
  logic [10:0] s_h, s_v;
  logic        s_hs, s_hb, s_vs, s_vb, s_fs;
  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) u_s (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount_out(s_h), .hsync_out(s_hs), .hblnk_out(s_hb),
    .vcount_out(s_v), .vsync_out(s_vs), .vblnk_out(s_vb), .frame_start(s_fs));

  // same tiny raster, active-low
  logic [10:0] n_h, n_v;
  logic        n_hs, n_hb, n_vs, n_vb, n_fs;
  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) u_n (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount_out(n_h), .hsync_out(n_hs), .hblnk_out(n_hb),
    .vcount_out(n_v), .vsync_out(n_vs), .vblnk_out(n_vb), .frame_start(n_fs));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  int cnt_a, cnt_b, cnt_c, cnt_d, nfs, n;

  initial begin
    // reset state
    step(2);
    chk("rst d_h", d_h, 0);      chk("rst d_v", d_v, 0);
    chk("rst d_hb", d_hb, 0);    chk("rst d_vb", d_vb, 0);
    chk("rst d_hs", d_hs, 0);    chk("rst d_vs", d_vs, 0);
    chk("rst d_fs", d_fs, 0);
    chk("rst g_hs", g_hs, 1);    chk("rst g_vs", g_vs, 1);

    // T counts posedges since release
    rst_n = 1'b1;
    step(1);   // T=1
    chk("exit d_h", d_h, 1);     chk("exit d_fs", d_fs, 0);
    chk("exit s_fs", s_fs, 0);
    step(639); // T=640
    chk("g_hb@640", g_hb, 1);    chk("d_hb@640", d_hb, 0);
    step(15);  // T=655
    chk("g_hs@655", g_hs, 1);
    step(1);   // T=656
    chk("g_hs@656", g_hs, 0);
    step(95);  // T=751
    chk("g_hs@751", g_hs, 0);
    step(1);   // T=752
    chk("g_hs@752", g_hs, 1);
    step(47);  // T=799
    chk("d_h@799", d_h, 799);    chk("d_hb@799", d_hb, 0);
    chk("g_h@799", g_h, 799);
    step(1);   // T=800
    chk("d_hb@800", d_hb, 1);    chk("g_h wrap", g_h, 0);
    chk("g_v wrap", g_v, 1);     chk("g_hb@0", g_hb, 0);
    step(39);  // T=839
    chk("d_hs@839", d_hs, 0);
    step(1);   // T=840
    chk("d_hs@840", d_hs, 1);
    step(127); // T=967
    chk("d_hs@967", d_hs, 1);
    step(1);   // T=968
    chk("d_hs@968", d_hs, 0);
    step(87);  // T=1055
    chk("d_h@1055", d_h, 1055);  chk("d_v@1055", d_v, 0);
    step(1);   // T=1056
    chk("d_h wrap", d_h, 0);     chk("d_v inc", d_v, 1);
    chk("d_hb@0", d_hb, 0);      chk("d_fs line", d_fs, 0);

    // one full line of default mode: 128 hsync cycles, 800 unblanked
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 1056; i++) begin
      step(1);
      if (d_hs) cnt_a++;
      if (!d_hb) cnt_b++;
    end        // T=2112
    chk("d_hs width", cnt_a, 128);
    chk("d_active", cnt_b, 800);
    chk("d_v line2", d_v, 2);    chk("d_h line2", d_h, 0);

    // freeze at hcount=500
    step(500); // T=2612
    chk("pre-freeze h", d_h, 500);
    en = 1'b0;
    step(10);
    chk("frozen h", d_h, 500);   chk("frozen v", d_v, 2);
    chk("frozen hb", d_hb, 0);
    en = 1'b1;
    step(1);
    chk("resume h", d_h, 501);

    // async reset mid-line at hcount=900 (sync and blank both active)
    step(399);
    chk("pre-rst h", d_h, 900);  chk("pre-rst hs", d_hs, 1);
    chk("pre-rst hb", d_hb, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async h", d_h, 0);      chk("async v", d_v, 0);
    chk("async hs", d_hs, 0);    chk("async hb", d_hb, 0);
    chk("async g_hs", g_hs, 1);
    step(3);
    rst_n = 1'b1;

    // tiny rasters: H=15, V=8, frame=120 cycles
    step(1);   // T=1
    chk("s exit h", s_h, 1);     chk("s exit fs", s_fs, 0);
    step(9);   // T=10
    chk("s_hs@10", s_hs, 1);     chk("n_hs@10", n_hs, 0);
    step(3);   // T=13
    chk("s_hs@13", s_hs, 0);     chk("n_hs@13", n_hs, 1);
    step(46);  // T=59
    chk("s_vb@59", s_vb, 0);     chk("s_v@59", s_v, 3);
    step(1);   // T=60
    chk("s_vb@60", s_vb, 1);     chk("s_v@60", s_v, 4);
    step(14);  // T=74
    chk("s_vs@74", s_vs, 0);
    step(1);   // T=75
    chk("s_vs@75", s_vs, 1);     chk("n_vs@75", n_vs, 0);
    step(29);  // T=104
    chk("s_vs@104", s_vs, 1);
    step(1);   // T=105
    chk("s_vs@105", s_vs, 0);    chk("n_vs@105", n_vs, 1);
    step(14);  // T=119
    chk("s_fs@119", s_fs, 0);    chk("s_h@119", s_h, 14);
    step(1);   // T=120
    chk("s_fs@120", s_fs, 1);    chk("s_v@120", s_v, 0);
    chk("s_vb@120", s_vb, 0);    chk("n_fs@120", n_fs, 1);

    // frame period and per-frame sync totals, bounded by 300 cycles
    n = 0; nfs = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    do begin
      step(1);
      n++;
      if (s_vs) cnt_a++;
      if (!n_vs) cnt_b++;
      if (!n_hs) cnt_c++;
      if (s_fs || d_fs) nfs++;
      if (s_vb) cnt_d++;
    end while (!s_fs && n < 300);
    chk("s frame period", n, 120);
    chk("s vsync cycles", cnt_a, 30);
    chk("n vsync low", cnt_b, 30);
    chk("n hsync low", cnt_c, 24);
    chk("fs pulses", nfs, 1);
    chk("s vblank cycles", cnt_d, 60);
    step(1);
    chk("s_fs one-shot", s_fs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
